// File: rtl/cpu_bus_target.sv
// CPU bus responder: work RAM, PPU register window, PRG-ROM port, open-bus latch
// and the OAM DMA engine that stalls the CPU while it copies a page into OAM.
module cpu_bus_target #(
  parameter int          RAM_AW   = 11,
  parameter logic [15:0] DMA_ADDR = 16'h4014,
  parameter logic [2:0]  OAM_REG  = 3'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_d_out,
  output logic [7:0]  cpu_d_in,
  output logic        cpu_ready,
  output logic [14:0] prg_addr,
  input  logic [7:0]  prg_data,
  output logic [2:0]  ppu_reg,
  output logic        ppu_rd,
  output logic        ppu_wr,
  output logic [7:0]  ppu_wdata,
  input  logic [7:0]  ppu_rdata,
  output logic        dma_busy
);

  // state  | meaning
  // IDLE   | CPU owns the bus
  // ALIGN  | first DMA dead cycle; parity decides whether ALIGN2 follows
  // ALIGN2 | extra alignment cycle on odd parity
  // RD     | DMA reads source byte {page,idx} into dbuf
  // WR     | DMA writes dbuf to the OAM data register
  typedef enum logic [2:0] {IDLE, ALIGN, ALIGN2, RD, WR} state_t;

  state_t      state, state_nxt;
  logic        par;
  logic [7:0]  ob, page, idx, dbuf;
  logic [7:0]  ram [2**RAM_AW];

  logic [15:0] bus_addr;
  logic        bus_valid, bus_write;
  logic [7:0]  bus_wdata, bus_rdata, bus_data;
  logic        sel_ram, sel_ppu, sel_prg, dma_start, ram_we;

  // Bus owner mux; strobes are suppressed while reset is held
  always_comb begin
    bus_addr  = cpu_addr;
    bus_valid = reset;
    bus_write = cpu_write;
    bus_wdata = cpu_d_out;
    case (state)
      IDLE: ;
      ALIGN, ALIGN2: begin
        bus_valid = 1'b0;
        bus_write = 1'b0;
      end
      RD: begin
        bus_addr  = {page, idx};
        bus_write = 1'b0;
      end
      WR: begin
        bus_addr  = {13'h0400, OAM_REG};
        bus_write = 1'b1;
        bus_wdata = dbuf;
      end
      default: bus_valid = 1'b0;
    endcase
  end

  assign sel_ram = (bus_addr[15:13] == 3'b000);
  assign sel_ppu = (bus_addr[15:13] == 3'b001);
  assign sel_prg = bus_addr[15];

  always_comb begin
    if (sel_ram)      bus_rdata = ram[bus_addr[RAM_AW-1:0]];
    else if (sel_ppu) bus_rdata = ppu_rdata;
    else if (sel_prg) bus_rdata = prg_data;
    else              bus_rdata = ob;
  end

  assign bus_data  = bus_write ? bus_wdata : bus_rdata;
  assign cpu_ready = (state == IDLE);
  assign dma_busy  = ~cpu_ready;
  assign cpu_d_in  = cpu_ready ? bus_rdata : ob;
  assign ppu_rd    = bus_valid & sel_ppu & ~bus_write;
  assign ppu_wr    = bus_valid & sel_ppu & bus_write;
  assign ppu_reg   = bus_addr[2:0];
  assign ppu_wdata = bus_wdata;
  assign prg_addr  = bus_addr[14:0];
  assign dma_start = bus_valid & cpu_ready & cpu_write & (cpu_addr == DMA_ADDR);
  assign ram_we    = bus_valid & cpu_ready & bus_write & sel_ram;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dma_start) state_nxt = ALIGN;
      ALIGN:   state_nxt = par ? ALIGN2 : RD;
      ALIGN2:  state_nxt = RD;
      RD:      state_nxt = WR;
      WR:      state_nxt = (idx == 8'hFF) ? IDLE : RD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[bus_addr[RAM_AW-1:0]] <= bus_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      par   <= 1'b0;
      ob    <= 8'h00;
      page  <= 8'h00;
      idx   <= 8'h00;
      dbuf  <= 8'h00;
    end else begin
      state <= state_nxt;
      par   <= ~par;
      if (bus_valid) ob <= bus_data;
      if (dma_start) begin
        page <= cpu_d_out;
        idx  <= 8'h00;
      end
      if (state == RD) dbuf <= bus_rdata;
      if (state == WR) idx <= idx + 8'd1;
    end
  end

endmodule
